carry_chain_sequencer: RTL

//  Downstream stage of the 8-bit prefix adder (sum[7:0], cout). Turns the fixed cin=0 byte adder into an
//  LSB-first multi-byte serial adder. Keeps the inter-byte carry and applies carry-in fix-up to each byte.

---
 rtl/carry_chain_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/carry_chain_sequencer.sv
// Multi-byte LSB-first serial adder stage: carry-in fix-up of cin=0 byte sums,
// inter-byte carry tracking and a 2-entry valid/ready output buffer.
module carry_chain_sequencer #(
  parameter int MAX_BYTES = 16,
  localparam int CW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_sum,
  input  logic          in_cout,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic [CW-1:0] out_idx,
  output logic          out_last,
  output logic          out_carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err_len,
  input  logic          clr_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic       ONE_BYTE = (MAX_BYTES == 1);

  typedef struct packed {
    logic [7:0]    data;
    logic [CW-1:0] idx;
    logic          last;
    logic          carry;
  } beat_t;

  logic [0:0]    state_q, state_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic [1:0]    cnt_q, cnt_d;
  beat_t         head_q, head_d;
  beat_t         tail_q, tail_d;

  logic          accept, pop, cin, c_out;
  logic          at_max, ends, forced;
  logic [7:0]    fix_byte;
  beat_t         new_beat;

  assign in_ready  = (cnt_q < 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign cin      = (state_q == S_RUN) & carry_q;
  assign fix_byte = in_sum + {7'd0, cin};
  assign c_out    = in_cout | (cin & (&in_sum));

  // A word also closes when it reaches the maximum length without in_last
  assign at_max = (state_q == S_RUN) && (idx_q == CW'(MAX_BYTES - 1));
  assign ends   = in_last | at_max | ((state_q == S_IDLE) & ONE_BYTE);
  assign forced = ends & ~in_last;

  always_comb begin
    new_beat.data  = fix_byte;
    new_beat.idx   = (state_q == S_IDLE) ? '0 : idx_q;
    new_beat.last  = ends;
    new_beat.carry = ends & c_out;
  end

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    if (accept) begin
      if (ends) begin
        state_d = S_IDLE;
        carry_d = 1'b0;
        idx_d   = '0;
      end else begin
        state_d = S_RUN;
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
      end
    end
  end

  assign err_d = clr_err ? 1'b0 : (err_q | (accept & forced));

  // in_ready excludes a push while full, so push+pop only occurs at count 1
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({accept, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = new_beat;
        else               tail_d = new_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: head_d = new_beat;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign out_data  = head_q.data;
  assign out_idx   = head_q.idx;
  assign out_last  = head_q.last;
  assign out_carry = head_q.carry;
  assign err_len   = err_q;

endmodule
